// File: rtl/guarded_fifo_pkg.sv
// rtl/guarded_fifo_pkg.sv - shared widths, defaults and sizing helpers for guarded_fifo_n
package guarded_fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Pointer width: enough bits to index DEPTH entries (DEPTH is a power of two)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: must represent 0..DEPTH inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/guarded_fifo_n_if.sv
// rtl/guarded_fifo_n_if.sv - enqueue/dequeue method bundle; clear method present only with GUARDED_FIFO_CLEAR_EN
interface guarded_fifo_n_if #(
    parameter int WIDTH = guarded_fifo_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = guarded_fifo_pkg::DEFAULT_DEPTH
) ();
    localparam int CW = guarded_fifo_pkg::cnt_width(DEPTH);

    logic             in_enq__ENA;
    logic [WIDTH-1:0] in_enq_v;
    logic             in_enq__RDY;
    logic             out_deq__ENA;
    logic             out_deq__RDY;
    logic [WIDTH-1:0] out_first;
    logic             out_first__RDY;
    logic [CW-1:0]    out_count;
`ifdef GUARDED_FIFO_CLEAR_EN
    logic             clear__ENA;
    logic             clear__RDY;
`endif

    // FIFO side
    modport slave (
        input  in_enq__ENA, in_enq_v, out_deq__ENA,
`ifdef GUARDED_FIFO_CLEAR_EN
        input  clear__ENA,
        output clear__RDY,
`endif
        output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, out_count
    );

    // Caller side
    modport master (
        output in_enq__ENA, in_enq_v, out_deq__ENA,
`ifdef GUARDED_FIFO_CLEAR_EN
        output clear__ENA,
        input  clear__RDY,
`endif
        input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, out_count
    );

endinterface

// File: rtl/guarded_fifo_mem.sv
// rtl/guarded_fifo_mem.sv - DEPTH x WIDTH register array, one sync write port, one async read port
module guarded_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage is deliberately not reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/guarded_fifo_n.sv
// rtl/guarded_fifo_n.sv - guarded FIFO with ENA/RDY methods; optional clear method under GUARDED_FIFO_CLEAR_EN
module guarded_fifo_n
    import guarded_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic            CLK,
    input  logic            RST,
    guarded_fifo_n_if.slave io
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic enq_rdy, deq_rdy, do_enq, do_deq, do_clear;

    // Method guards come from registered state only, never from any ENA.
    //   in_enq   guard: count != DEPTH ; reads wr_ptr, count ; writes mem[wr_ptr], wr_ptr, count
    //   out_deq  guard: count != 0     ; reads rd_ptr, count ; writes rd_ptr, count
    //   out_first guard: count != 0    ; reads mem[rd_ptr]   ; writes nothing
    //   clear    guard: always ready   ; reads nothing       ; writes rd_ptr, wr_ptr, count
    assign enq_rdy = (count_q != CW'(DEPTH));
    assign deq_rdy = (count_q != '0);

`ifdef GUARDED_FIFO_CLEAR_EN
    assign io.clear__RDY = 1'b1;
    assign do_clear      = io.clear__ENA;
`else
    assign do_clear      = 1'b0;
`endif

    // Clear wins over both methods, so a cleared cycle also suppresses the storage write
    assign do_enq = io.in_enq__ENA  && enq_rdy && !do_clear;
    assign do_deq = io.out_deq__ENA && deq_rdy && !do_clear;

    // Next-state for pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset empties the FIFO regardless of concurrent requests
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    guarded_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (do_enq),
        .waddr (wr_ptr_q),
        .wdata (io.in_enq_v),
        .raddr (rd_ptr_q),
        .rdata (io.out_first)
    );

    assign io.in_enq__RDY    = enq_rdy;
    assign io.out_deq__RDY   = deq_rdy;
    assign io.out_first__RDY = deq_rdy;
    assign io.out_count      = count_q;

endmodule

// File: tb/tb_guarded_fifo_n.sv
// tb/tb_guarded_fifo_n.sv - scoreboard bench for guarded_fifo_n (WIDTH=32, DEPTH=4), clear path with GUARDED_FIFO_CLEAR_EN
module tb_guarded_fifo_n;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] sb[$];
    bit               model_valid = 1'b0;

    guarded_fifo_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    guarded_fifo_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check state at negedge, drive inputs, advance model after posedge
    task automatic step(input bit enq, input logic [WIDTH-1:0] d, input bit deq,
                        input bit do_rst, input bit clr, input string tag);
        int  n;
        bit  e_ok;
        bit  d_ok;
        @(negedge clk);
        n = sb.size();
        if (model_valid) begin
            chk({tag, ":count"},     64'(bus.out_count),      64'(n));
            chk({tag, ":enq_rdy"},   64'(bus.in_enq__RDY),    64'(n != DEPTH));
            chk({tag, ":deq_rdy"},   64'(bus.out_deq__RDY),   64'(n != 0));
            chk({tag, ":first_rdy"}, 64'(bus.out_first__RDY), 64'(n != 0));
            if (n != 0) begin
                chk({tag, ":first"}, 64'(bus.out_first), 64'(sb[0]));
            end
        end
        bus.in_enq__ENA  = enq;
        bus.in_enq_v     = d;
        bus.out_deq__ENA = deq;
        rst              = do_rst;
`ifdef GUARDED_FIFO_CLEAR_EN
        bus.clear__ENA   = clr;
`endif
        @(posedge clk);
        if (do_rst || (clr && model_valid)) begin
            sb.delete();
            model_valid = do_rst ? 1'b1 : model_valid;
        end else if (model_valid) begin
            e_ok = enq && (n != DEPTH);
            d_ok = deq && (n != 0);
            if (d_ok) void'(sb.pop_front());
            if (e_ok) sb.push_back(d);
        end
    endtask

    initial begin
        bus.in_enq__ENA  = 1'b0;
        bus.in_enq_v     = '0;
        bus.out_deq__ENA = 1'b0;
`ifdef GUARDED_FIFO_CLEAR_EN
        bus.clear__ENA   = 1'b0;
        chk("clear_rdy", 64'(bus.clear__RDY), 64'(1));
`endif
        step(0, 0, 0, 1, 0, "rst0");
        step(1, 32'hDEAD, 1, 1, 0, "rst1");

        // fill to full on consecutive cycles
        step(1, 32'hA1, 0, 0, 0, "fill1");
        step(1, 32'hA2, 0, 0, 0, "fill2");
        step(1, 32'hA3, 0, 0, 0, "fill3");
        step(1, 32'hA4, 0, 0, 0, "fill4");

        // full: enqueue blocked even with dequeue the same cycle
        step(1, 32'hFF, 1, 0, 0, "full_enq_deq");
        step(0, 0, 1, 0, 0, "to_two");

        // steady-state simultaneous enq/deq across pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h10 + 32'(i), 1, 0, 0, "flow");
        end

        // drain, then over-dequeue an empty FIFO
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, "drain");
        end

        // empty: dequeue blocked while enqueue lands
        step(1, 32'h55, 1, 0, 0, "empty_enq_deq");
        step(1, 32'h56, 0, 0, 0, "to_two_b");
        step(1, 32'h57, 0, 0, 0, "to_three");

        // reset mid-operation with enqueue asserted
        step(1, 32'h99, 0, 1, 0, "mid_rst");
        step(0, 0, 0, 0, 0, "post_rst");

`ifdef GUARDED_FIFO_CLEAR_EN
        step(1, 32'h61, 0, 0, 0, "clr_fill1");
        step(1, 32'h62, 0, 0, 0, "clr_fill2");
        step(1, 32'h77, 1, 0, 1, "clear");
        step(0, 0, 0, 0, 0, "post_clear");
`endif

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
                 0, 0, "rand");
        end
        step(0, 0, 0, 0, 0, "final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
